// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-side FIFO pointer and flag controller.
// Keeps a binary write pointer, publishes it Gray-coded for the read-domain
// synchroniser, and derives registered full / almost-full / fill-level flags
// from the synchronised Gray read pointer.
// Optional overflow accounting (sticky wovf, saturating wdrop_cnt) is built
// only when WPTR_FULL_OVF_STATS_EN is defined; otherwise both outputs are 0.
module wptr_full_ctrl #(
    parameter int ADDR_WIDTH  = 3,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  wovf_clr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wovf,
    output logic [7:0]            wdrop_cnt
);

    localparam logic [ADDR_WIDTH:0] AFULL_THR = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

    logic [ADDR_WIDTH:0]   r_wbin;
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_wfull;
    logic                  r_walmost_full;
    logic [ADDR_WIDTH:0]   r_wlevel;

    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_wbin_next;
    logic [ADDR_WIDTH:0]   w_wgray_next;
    logic [ADDR_WIDTH:0]   w_rbin;
    logic [ADDR_WIDTH:0]   w_level_next;
    logic                  w_full_next;

    assign w_accept     = winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + (ADDR_WIDTH + 1)'(w_accept);
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Gray-to-binary of the synchronised read pointer: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        w_rbin = '0;
        for (int unsigned i = 0; i < ADDR_WIDTH + 1; i++) begin
            w_rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // Full when the next write pointer equals the read pointer one lap ahead
    // (Gray form: top two bits inverted, remaining bits equal).
    assign w_full_next  = (w_wgray_next ==
                           {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]});
    assign w_level_next = w_wbin_next - w_rbin;

    // Pointer, address and flag registers, all advanced by the accepting edge.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_waddr        <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_waddr        <= w_wbin_next[ADDR_WIDTH-1:0];
            r_wfull        <= w_full_next;
            r_walmost_full <= (w_level_next >= AFULL_THR);
            r_wlevel       <= w_level_next;
        end
    end

    assign wen          = winc & ~r_wfull & ~wrst;
    assign waddr        = r_waddr;
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;

`ifdef WPTR_FULL_OVF_STATS_EN
    logic       r_wovf;
    logic [7:0] r_wdrop_cnt;
    logic       w_reject;

    assign w_reject = winc & r_wfull;

    // Overflow accounting: a rejected write wins over a same-cycle clear and restarts the count at 1.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wovf      <= 1'b0;
            r_wdrop_cnt <= '0;
        end else if (w_reject) begin
            r_wovf <= 1'b1;
            if (wovf_clr) begin
                r_wdrop_cnt <= 8'd1;
            end else if (r_wdrop_cnt != '1) begin
                r_wdrop_cnt <= r_wdrop_cnt + 8'd1;
            end
        end else if (wovf_clr) begin
            r_wovf      <= 1'b0;
            r_wdrop_cnt <= '0;
        end
    end

    assign wovf      = r_wovf;
    assign wdrop_cnt = r_wdrop_cnt;
`else
    logic w_unused_ovf_clr;

    assign w_unused_ovf_clr = wovf_clr;
    assign wovf             = 1'b0;
    assign wdrop_cnt        = '0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed table plus hand sequences for wptr_full_ctrl
// (ADDR_WIDTH=3, AFULL_LEVEL=6). Overflow expectations follow
// WPTR_FULL_OVF_STATS_EN.
module tb_wptr_full_ctrl;

`ifdef WPTR_FULL_OVF_STATS_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       wclk = 1'b0;
    logic       wrst, winc, wovf_clr;
    logic [3:0] wq2_rptr;
    logic       wen, wfull, walmost_full, wovf;
    logic [2:0] waddr;
    logic [3:0] wptr, wlevel;
    logic [7:0] wdrop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 wclk = ~wclk;

    wptr_full_ctrl #(.ADDR_WIDTH(3), .AFULL_LEVEL(6)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
        .wovf_clr(wovf_clr), .wen(wen), .waddr(waddr), .wptr(wptr),
        .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
        .wovf(wovf), .wdrop_cnt(wdrop_cnt)
    );

    typedef struct {
        logic       rst, inc;
        logic [3:0] rptr;
        logic       clr;
        logic       e_wen;
        logic [3:0] e_wptr;
        logic [2:0] e_waddr;
        logic       e_full, e_af;
        logic [3:0] e_lvl;
        logic       e_ovf;
        logic [7:0] e_drop;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic rst, logic inc, logic [3:0] rptr, logic clr,
                                logic e_wen, logic [3:0] e_wptr, logic [2:0] e_waddr,
                                logic e_full, logic e_af, logic [3:0] e_lvl,
                                logic e_ovf, logic [7:0] e_drop);
        vec_t v;
        v.rst = rst; v.inc = inc; v.rptr = rptr; v.clr = clr;
        v.e_wen = e_wen; v.e_wptr = e_wptr; v.e_waddr = e_waddr;
        v.e_full = e_full; v.e_af = e_af; v.e_lvl = e_lvl;
        v.e_ovf = e_ovf; v.e_drop = e_drop;
        return v;
    endfunction

    function automatic logic [3:0] gray(int unsigned b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic inc, logic [3:0] rptr, logic clr);
        @(negedge wclk);
        wrst = rst; winc = inc; wq2_rptr = rptr; wovf_clr = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_wptr"}, 32'(wptr), 0);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_wfull"}, 32'(wfull), 0);
        chk({tag, "_afull"}, 32'(walmost_full), 0);
        chk({tag, "_wlevel"}, 32'(wlevel), 0);
        chk({tag, "_wovf"}, 32'(wovf), 0);
        chk({tag, "_drop"}, 32'(wdrop_cnt), 0);
    endtask

    task automatic do_reset(string tag);
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        chk_all_zero(tag);
    endtask

    initial begin
        wrst = 1'b1; winc = 1'b0; wq2_rptr = '0; wovf_clr = 1'b0;

        //           rst inc rptr clr | wen wptr waddr full af lvl ovf drop
        tbl[0]  = mk(1, 1, 4'd0, 0,  0, 4'd0,  3'd0, 0, 0, 4'd0, 0, 8'd0);
        tbl[1]  = mk(0, 1, 4'd0, 0,  1, 4'd1,  3'd1, 0, 0, 4'd1, 0, 8'd0);
        tbl[2]  = mk(0, 1, 4'd0, 0,  1, 4'd3,  3'd2, 0, 0, 4'd2, 0, 8'd0);
        tbl[3]  = mk(0, 1, 4'd0, 0,  1, 4'd2,  3'd3, 0, 0, 4'd3, 0, 8'd0);
        tbl[4]  = mk(0, 1, 4'd0, 0,  1, 4'd6,  3'd4, 0, 0, 4'd4, 0, 8'd0);
        tbl[5]  = mk(0, 1, 4'd0, 0,  1, 4'd7,  3'd5, 0, 0, 4'd5, 0, 8'd0);
        tbl[6]  = mk(0, 1, 4'd0, 0,  1, 4'd5,  3'd6, 0, 1, 4'd6, 0, 8'd0);
        tbl[7]  = mk(0, 1, 4'd0, 0,  1, 4'd4,  3'd7, 0, 1, 4'd7, 0, 8'd0);
        tbl[8]  = mk(0, 1, 4'd0, 0,  1, 4'd12, 3'd0, 1, 1, 4'd8, 0, 8'd0);
        tbl[9]  = mk(0, 1, 4'd0, 0,  0, 4'd12, 3'd0, 1, 1, 4'd8, OVF_ON, OVF_ON ? 8'd1 : 8'd0);
        tbl[10] = mk(0, 1, 4'd0, 0,  0, 4'd12, 3'd0, 1, 1, 4'd8, OVF_ON, OVF_ON ? 8'd2 : 8'd0);
        tbl[11] = mk(0, 1, 4'd0, 0,  0, 4'd12, 3'd0, 1, 1, 4'd8, OVF_ON, OVF_ON ? 8'd3 : 8'd0);
        tbl[12] = mk(0, 0, 4'd1, 0,  0, 4'd12, 3'd0, 0, 1, 4'd7, OVF_ON, OVF_ON ? 8'd3 : 8'd0);
        tbl[13] = mk(0, 1, 4'd1, 0,  1, 4'd13, 3'd1, 1, 1, 4'd8, OVF_ON, OVF_ON ? 8'd3 : 8'd0);
        tbl[14] = mk(0, 1, 4'd1, 1,  0, 4'd13, 3'd1, 1, 1, 4'd8, OVF_ON, OVF_ON ? 8'd1 : 8'd0);
        tbl[15] = mk(0, 0, 4'd1, 1,  0, 4'd13, 3'd1, 1, 1, 4'd8, 0, 8'd0);

        // Fill, write-while-full, drain release, clear/reject collision.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].inc, tbl[i].rptr, tbl[i].clr);
            chk($sformatf("v%0d_wen", i), 32'(wen), 32'(tbl[i].e_wen));
            tick();
            chk($sformatf("v%0d_wptr", i), 32'(wptr), 32'(tbl[i].e_wptr));
            chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(tbl[i].e_waddr));
            chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'(tbl[i].e_full));
            chk($sformatf("v%0d_afull", i), 32'(walmost_full), 32'(tbl[i].e_af));
            chk($sformatf("v%0d_wlevel", i), 32'(wlevel), 32'(tbl[i].e_lvl));
            chk($sformatf("v%0d_wovf", i), 32'(wovf), 32'(tbl[i].e_ovf));
            chk($sformatf("v%0d_drop", i), 32'(wdrop_cnt), 32'(tbl[i].e_drop));
        end

        // Wrap-around: read pointer trails by one entry for 40 writes.
        do_reset("wrap_rst");
        for (int unsigned i = 0; i < 40; i++) begin
            drive(1'b0, 1'b1, gray(i % 16), 1'b0);
            chk($sformatf("wrap%0d_wen", i), 32'(wen), 1);
            tick();
            chk($sformatf("wrap%0d_wptr", i), 32'(wptr), 32'(gray((i + 1) % 16)));
            chk($sformatf("wrap%0d_waddr", i), 32'(waddr), (i + 1) % 8);
            chk($sformatf("wrap%0d_wfull", i), 32'(wfull), 0);
            chk($sformatf("wrap%0d_wlevel", i), 32'(wlevel), 1);
        end

        // Reset mid-stream at level 5 with a write pending.
        do_reset("mid_rst0");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 4'd0, 1'b0);
            tick();
        end
        chk("mid_level5", 32'(wlevel), 5);
        chk("mid_wptr5", 32'(wptr), 7);
        drive(1'b1, 1'b1, 4'd0, 1'b0);
        chk("mid_rst_wen", 32'(wen), 0);
        tick();
        chk_all_zero("mid_rst");

        // Drop counter saturation, then a plain clear.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 4'd0, 1'b0);
            tick();
        end
        chk("sat_full", 32'(wfull), 1);
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, 1'b1, 4'd0, 1'b0);
            tick();
        end
        chk("sat_drop", 32'(wdrop_cnt), OVF_ON ? 255 : 0);
        chk("sat_wovf", 32'(wovf), 32'(OVF_ON));
        chk("sat_wptr", 32'(wptr), 12);
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        tick();
        chk("clr_wovf", 32'(wovf), 0);
        chk("clr_drop", 32'(wdrop_cnt), 0);
        chk("clr_wfull", 32'(wfull), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Parametrised write-side pointer and flag controller for the team's FIFOs. It is the successor to the basic write-pointer/full block and adds:
- a Gray-coded pointer output for crossing to the read domain, with a separate binary RAM address;
- a registered full flag, a programmable almost-full flag and a fill-level count;
- optional overflow accounting.

It sits in the write clock domain between the producer, the FIFO RAM write port and the read-pointer synchroniser.

## Interface
- ADDR_WIDTH, 3, RAM address width; depth = 2^ADDR_WIDTH; legal range ≥ 2
- AFULL_LEVEL, 6, fill level at or above which walmost_full asserts; legal range 1..2^ADDR_WIDTH
- wclk  in  1  write-domain clock; all logic on rising edge
- wrst  in  1  synchronous, active-high reset
- winc  in  1  producer write request
- wq2_rptr  in  ADDR_WIDTH+1  read pointer, Gray code, already synchronised into wclk
- wovf_clr  in  1  synchronous clear of overflow status
- wen  out  1  RAM write strobe, combinational: winc & ~wfull & ~wrst
- waddr  out  ADDR_WIDTH  RAM write address, registered
- wptr  out  ADDR_WIDTH+1  write pointer, Gray code, registered, to read-domain synchroniser
- wfull  out  1  FIFO full, registered
- walmost_full  out  1  wlevel ≥ AFULL_LEVEL, registered
- wlevel  out  ADDR_WIDTH+1  entries occupied as seen from write domain, registered
- wovf  out  1  sticky overflow flag
- wdrop_cnt  out  8  count of rejected writes, saturating

## Operation
- Internal binary pointer wbin, ADDR_WIDTH+1 bits; wraps modulo 2^(ADDR_WIDTH+1).
- Write acceptance:
  - accept = winc & ~wfull.
  - wbin_next = wbin + accept.
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Every edge registers:
  - wbin ← wbin_next
  - wptr ← wgray_next
  - waddr ← wbin_next[ADDR_WIDTH-1:0]
- The RAM write address is waddr: the binary address of the current wbin.
- Full detection: wfull ← (wgray_next == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
- Level:
  - Convert wq2_rptr from Gray to binary rbin (XOR prefix, combinational).
  - wlevel ← (wbin_next − rbin) mod 2^(ADDR_WIDTH+1).
  - walmost_full ← (wbin_next − rbin) ≥ AFULL_LEVEL.
- Flags are conservative:
  - A stale synchronised read pointer can only over-report occupancy, never under-report it.
  - wfull therefore never lets a write overrun unread data.
- Overflow: a write is rejected when winc & wfull. Rejected writes do not move the pointer or write the RAM.
- Reset (wrst high at edge) sets all registered outputs to 0: wbin, wptr, waddr, wfull, walmost_full, wlevel, wovf, wdrop_cnt. Reset overrides any write request.
- Reset mid-operation: pointer returns to 0 regardless of winc. The read domain must be reset together with this block.

## Timing
- wen is combinational in the cycle of the request. wptr, waddr, wlevel and the flags update at the same edge that accepts the write.
- Full is set by the edge that accepts the final free slot. It is low by the first edge after a changed wq2_rptr frees a slot.
- Synchroniser latency (2 wclk) adds to release latency. That latency is outside this block.
- Simultaneous write and read-pointer change in one cycle: both apply in the same wlevel computation, so the level is unchanged.
- Pointer wrap at 2^(ADDR_WIDTH+1) is transparent; full and level remain correct across wrap.

## Configuration
- Macro: WPTR_FULL_OVF_STATS_EN.
- Defined:
  - wovf ← 1 on any rejected write; holds until wovf_clr or wrst.
  - wdrop_cnt increments per rejected write and saturates at 255.
  - wovf_clr clears both. If wovf_clr and a rejected write occur in the same cycle, the set wins: wovf = 1, wdrop_cnt = 1.
- Undefined: wovf and wdrop_cnt are tied to 0, wovf_clr is ignored, and no overflow registers are synthesised.

## Test plan
All cases use ADDR_WIDTH = 3 and AFULL_LEVEL = 6.
- Fill from empty: wrst, then winc high for 8 cycles with wq2_rptr = 0 → wptr steps 1,3,2,6,7,5,4,12. walmost_full rises on the 6th accepting edge; wfull and wlevel = 8 on the 8th.
- Write while full: winc high 3 more cycles → wen = 0, wptr stays 4'b1100. With macro: wovf = 1, wdrop_cnt = 3. Without macro: both 0.
- Drain release: from full, wq2_rptr = 4'b0001 → wfull = 0 and wlevel = 7 after one edge. The next winc is accepted with waddr = 0.
- Wrap-around: stream 40 writes with wq2_rptr tracking one entry behind → wptr wraps past 4'b1000 back to 0 repeatedly. wfull never asserts and wlevel stays 1.
- Reset mid-stream: wrst high for one cycle while winc is high at level 5 → wen = 0 that cycle and all outputs are 0 after the edge.
- Clear/overflow collision (macro on): wovf_clr high in the same cycle as a rejected write → wovf = 1, wdrop_cnt = 1.
